// File: rtl/fma9_cpa_norm_prep_pkg.sv
// Shared widths and stage-1 payload for the FMA9 carry-propagate / normalise-prep stage.
package fma9_cpa_norm_prep_pkg;

  localparam int unsigned SIG_WIDTH = 23;
  localparam int unsigned MW        = 2 * (SIG_WIDTH + 1) + 5;
  localparam int unsigned LO_W      = MW / 2;
  localparam int unsigned HI_W      = MW - LO_W;
  localparam int unsigned TAG_W     = 8;
  localparam int unsigned LZC_W     = $clog2(MW + 1);

  // Stage-1 register contents: resolved low half plus raw upper halves.
  typedef struct packed {
    logic [HI_W-1:0]  sum_hi;
    logic [HI_W-1:0]  carry_hi;
    logic [LO_W-1:0]  lo;
    logic             c1;
    logic [TAG_W-1:0] tag;
  } s1_t;

endpackage

// File: rtl/fma9_lzc.sv
// Combinational MW-bit priority leading-zero counter; all-zero input yields MW.
module fma9_lzc
  import fma9_cpa_norm_prep_pkg::*;
(
  input  logic [MW-1:0]    din_i,
  output logic [LZC_W-1:0] lzc_o
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    lzc_o = LZC_W'(MW);
    for (int i = 0; i < int'(MW); i++) begin
      if (din_i[i]) lzc_o = LZC_W'(int'(MW) - 1 - i);
    end
  end

endmodule

// File: rtl/fma9_cpa_norm_prep.sv
// Two-stage split CPA resolving the compressor's sum/carry pair into sign + magnitude.
// Optional leading-zero count enabled by FMA9_CPA_LZC_EN.
module fma9_cpa_norm_prep
  import fma9_cpa_norm_prep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MW-1:0]    man_sum,
  input  logic [MW-1:0]    man_carry,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [MW-1:0]    out_mag,
  output logic             out_zero,
  output logic [LZC_W-1:0] out_lzc,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sign_q, out_sign_d;
  logic [MW-1:0]    out_mag_q, out_mag_d;
  logic             out_zero_q, out_zero_d;
  logic [LZC_W-1:0] out_lzc_q, out_lzc_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             s2_free, accept, advance;
  logic [LO_W:0]    lo_sum;
  logic [HI_W-1:0]  hi_sum;
  logic [MW-1:0]    full, mag;
  logic [LZC_W-1:0] lzc_c;

  assign s2_free  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid_q && s2_free;

  assign lo_sum = {1'b0, man_sum[LO_W-1:0]} + {1'b0, man_carry[LO_W-1:0]};
  assign hi_sum = s1_q.sum_hi + s1_q.carry_hi + HI_W'(s1_q.c1);
  assign full   = {hi_sum, s1_q.lo};
  // Most negative value wraps to itself; downstream treats that as documented.
  assign mag    = full[MW-1] ? (~full + MW'(1)) : full;

`ifdef FMA9_CPA_LZC_EN
  fma9_lzc u_lzc (
    .din_i (mag),
    .lzc_o (lzc_c)
  );
`else
  assign lzc_c = '0;
`endif

  // Next-state for both stages; registers hold unless their stage moves.
  always_comb begin
    s1_valid_d  = accept || (s1_valid_q && !s2_free);
    s1_d        = s1_q;
    out_valid_d = advance || (out_valid_q && !out_ready);
    out_sign_d  = out_sign_q;
    out_mag_d   = out_mag_q;
    out_zero_d  = out_zero_q;
    out_lzc_d   = out_lzc_q;
    out_tag_d   = out_tag_q;
    if (accept) begin
      s1_d.sum_hi   = man_sum[MW-1:LO_W];
      s1_d.carry_hi = man_carry[MW-1:LO_W];
      s1_d.lo       = lo_sum[LO_W-1:0];
      s1_d.c1       = lo_sum[LO_W];
      s1_d.tag      = in_tag;
    end
    if (advance) begin
      out_sign_d = full[MW-1];
      out_mag_d  = mag;
      out_zero_d = (full == '0);
      out_lzc_d  = lzc_c;
      out_tag_d  = s1_q.tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_mag_q   <= '0;
      out_zero_q  <= 1'b0;
      out_lzc_q   <= '0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_mag_q   <= out_mag_d;
      out_zero_q  <= out_zero_d;
      out_lzc_q   <= out_lzc_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_mag   = out_mag_q;
  assign out_zero  = out_zero_q;
  assign out_lzc   = out_lzc_q;
  assign out_tag   = out_tag_q;

endmodule
